// File: rtl/tabla_sweep_checker_if.sv
// tabla_sweep_checker_if: stimulus/response bundle between the sweep checker and a truth-table harness
interface tabla_sweep_checker_if #(parameter int N = 3);
    logic start;
    logic y_in;
    logic [N-1:0] vec;
    logic busy;
    logic done;
    logic pass;
    logic [N:0] err_count;
    logic [N-1:0] first_err;
    modport master(input start, y_in, output vec, busy, done, pass, err_count, first_err);
    modport slave(output start, y_in, input vec, busy, done, pass, err_count, first_err);
endinterface

// File: rtl/tabla_sweep_checker.sv
// tabla_sweep_checker: sweeps every input vector of a truth table and checks y_in against EXPECTED
module tabla_sweep_checker #(
    parameter int N = 3,
    parameter logic [2**N-1:0] EXPECTED = '0,
    parameter bit DESCENDING = 1'b0
) (
    input logic clk,
    input logic reset,
    tabla_sweep_checker_if.master bus
);
    localparam logic [N-1:0] FIRST = {N{DESCENDING}};
    localparam logic [N-1:0] LAST = {N{~DESCENDING}};
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
    state_t state, state_nx;
    logic go, last, miss;
    assign go = bus.start && (state == IDLE || state == DONE);
    assign last = bus.vec == LAST;
    assign miss = bus.y_in != EXPECTED[bus.vec];
    assign bus.busy = state == DRIVE || state == SAMPLE;
    assign bus.done = state == DONE;
    assign bus.pass = state == DONE && bus.err_count == '0;
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = bus.start ? DRIVE : state;
            DRIVE: state_nx = SAMPLE;
            SAMPLE: state_nx = last ? DONE : DRIVE;
            default: state_nx = IDLE;
        endcase
    end
    // terminal index is tested before stepping, so vec never wraps
    always_ff @(posedge clk) begin
        if (reset || go) begin
            bus.vec <= FIRST;
            bus.err_count <= '0;
            bus.first_err <= '0;
        end else if (state == SAMPLE) begin
            if (miss) begin
                bus.err_count <= bus.err_count + 1'b1;
                if (bus.err_count == '0) bus.first_err <= bus.vec;
            end
            if (!last) bus.vec <= DESCENDING ? bus.vec - 1'b1 : bus.vec + 1'b1;
        end
    end
endmodule

// File: tb/tb_tabla_sweep_checker.sv
// tb_tabla_sweep_checker: directed checks of ascending XOR3 and descending all-ones sweeps
module tb_tabla_sweep_checker;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flip5 = 1'b0;
    int n_chk = 0;
    int n_pass = 0;
    always #5 clk = ~clk;
    tabla_sweep_checker_if #(.N(3)) bus_a();
    tabla_sweep_checker_if #(.N(4)) bus_b();
    assign bus_a.y_in = (^bus_a.vec) ^ (flip5 && bus_a.vec == 3'd5);
    assign bus_b.y_in = 1'b0;
    tabla_sweep_checker #(.N(3), .EXPECTED(8'b1001_0110), .DESCENDING(1'b0)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    tabla_sweep_checker #(.N(4), .EXPECTED(16'hFFFF), .DESCENDING(1'b1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic pulse_a();
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
    endtask
    task automatic done_a(input int err, input int first, input int pass);
        chk("a_done", bus_a.done, 1);
        chk("a_busy_done", bus_a.busy, 0);
        chk("a_err", bus_a.err_count, err);
        if (err != 0) chk("a_first", bus_a.first_err, first);
        chk("a_pass", bus_a.pass, pass);
    endtask
    initial begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        step(2);
        chk("rst_vec_a", bus_a.vec, 0);
        chk("rst_vec_b", bus_b.vec, 15);
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_done", bus_a.done, 0);
        chk("rst_pass", bus_a.pass, 0);
        chk("rst_err", bus_a.err_count, 0);
        chk("rst_first", bus_a.first_err, 0);
        reset = 1'b0;
        step(2);
        chk("idle_hold", bus_a.busy, 0);
        // clean ascending sweep
        pulse_a();
        chk("e0_busy", bus_a.busy, 1);
        chk("e0_vec", bus_a.vec, 0);
        chk("e0_done", bus_a.done, 0);
        for (int e = 1; e <= 16; e++) begin
            step();
            chk("a_vec_seq", bus_a.vec, e < 16 ? e / 2 : 7);
            chk("a_busy_seq", bus_a.busy, e < 16 ? 1 : 0);
            chk("a_done_seq", bus_a.done, e == 16 ? 1 : 0);
        end
        done_a(0, 0, 1);
        // single fault at vec=5, compared at edge 12
        flip5 = 1'b1;
        pulse_a();
        chk("rearm_done", bus_a.done, 0);
        chk("rearm_pass", bus_a.pass, 0);
        step(11);
        chk("err_before", bus_a.err_count, 0);
        step();
        chk("err_after", bus_a.err_count, 1);
        step(4);
        done_a(1, 5, 0);
        // descending all-wrong sweep
        bus_b.start = 1'b1;
        step();
        bus_b.start = 1'b0;
        chk("b_e0_vec", bus_b.vec, 15);
        chk("b_e0_busy", bus_b.busy, 1);
        for (int e = 1; e <= 32; e++) begin
            step();
            chk("b_vec_seq", bus_b.vec, e < 32 ? 15 - e / 2 : 0);
            chk("b_err_seq", bus_b.err_count, e / 2);
            chk("b_done_seq", bus_b.done, e == 32 ? 1 : 0);
        end
        chk("b_err", bus_b.err_count, 16);
        chk("b_first", bus_b.first_err, 15);
        chk("b_pass", bus_b.pass, 0);
        // reset during SAMPLE of vec=3
        flip5 = 1'b0;
        pulse_a();
        step(7);
        chk("mid_vec", bus_a.vec, 3);
        chk("mid_busy", bus_a.busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_vec", bus_a.vec, 0);
        chk("mrst_busy", bus_a.busy, 0);
        chk("mrst_done", bus_a.done, 0);
        chk("mrst_err", bus_a.err_count, 0);
        pulse_a();
        step(16);
        done_a(0, 0, 1);
        // start ignored while busy, results unchanged
        flip5 = 1'b1;
        pulse_a();
        step(4);
        chk("busy_vec2", bus_a.vec, 2);
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
        chk("ign_drive_vec", bus_a.vec, 2);
        chk("ign_drive_busy", bus_a.busy, 1);
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
        chk("ign_sample_vec", bus_a.vec, 3);
        step(10);
        done_a(1, 5, 0);
        // restart from DONE with a correct model
        flip5 = 1'b0;
        pulse_a();
        chk("re_done", bus_a.done, 0);
        chk("re_pass", bus_a.pass, 0);
        chk("re_err", bus_a.err_count, 0);
        chk("re_first", bus_a.first_err, 0);
        step(15);
        chk("re_e15_done", bus_a.done, 0);
        step();
        done_a(0, 0, 1);
        // reset beats a simultaneous start
        reset = 1'b1;
        bus_a.start = 1'b1;
        step();
        reset = 1'b0;
        bus_a.start = 1'b0;
        chk("rw_done", bus_a.done, 0);
        chk("rw_busy", bus_a.busy, 0);
        step();
        chk("rw_idle", bus_a.busy, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
